lcd_display_controller: RTL and testbench
=========================================

Name: lcd_display_controller

Overview:
- Consumer end of the mini-CPU display interface.
- Accepts one display request per executed instruction (opcode, destination address, 16-bit signed result) over a valid/ready handshake.
- Formats the request as two 16-character ASCII lines and drives an HD44780-compatible 16x2 LCD in 8-bit, write-only mode.
- Owns the power-up init sequence and all LCD timing; the CPU never touches LCD pins.

Parameters:
INIT_WAIT_CYC, 1000000, cycles idle after reset before the first command (20 ms @ 50 MHz)
EN_PULSE_CYC, 25, lcd_en high width in cycles (500 ns)
CMD_WAIT_CYC, 2000, wait after lcd_en falls for any byte except 0x01 (40 us)
CLR_WAIT_CYC, 82000, wait after lcd_en falls for command 0x01 (1.64 ms)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present; producer holds it and all fields stable until accepted
req_ready  out  1  controller can accept a request
req_opcode  in  3  CPU opcode: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 DISPLAY
req_addr  in  4  destination register address
req_value  in  16  two's-complement result
lcd_data  out  8  LCD DB7..DB0
lcd_rs  out  1  0 = command, 1 = character
lcd_rw  out  1  constant 0
lcd_en  out  1  LCD enable strobe

Behaviour:
- Reset (async, takes effect immediately): lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, req_ready=0, FSM=INIT_WAIT, all counters 0.
- Reset mid-operation aborts the current byte and request. On release, full init is redone and no partial text is resumed.
- Byte write primitive:
  - Cycle 0: drive lcd_data/lcd_rs and raise lcd_en.
  - lcd_en stays high EN_PULSE_CYC cycles, then falls.
  - lcd_data/lcd_rs stay stable through the following wait of CMD_WAIT_CYC cycles (CLR_WAIT_CYC if command 0x01).
  - Next byte starts the cycle after the wait ends.
- FSM:
  - INIT_WAIT: count INIT_WAIT_CYC, then go to INIT_CMD.
  - INIT_CMD: write commands 0x38, 0x0C, 0x06, 0x01 in order, then go to IDLE.
  - IDLE: req_ready=1. Transfer occurs on a cycle with req_valid&&req_ready. Capture all fields that cycle; req_ready=0 from the next cycle.
  - After capture, opcode 110 goes to CLEAR: write command 0x01, then IDLE.
  - Any other opcode goes to CONVERT: start bcd_converter on |req_value|, then wait for done.
  - LINE1: command 0x80, then 16 characters: mnemonic padded to 4 chars ("LOAD","ADD ","ADDI","SUB ","SUBI","MUL ","DISP" for 111), 6 spaces, '[', req_addr as 4 binary digits MSB first ('0'/'1'), ']'.
  - LINE2: command 0xC0, then 16 characters: 10 spaces, sign ('+' if bit15=0, '-' otherwise), 5 zero-padded decimal digits of the magnitude.
  - After LINE2, return to IDLE.
- Arithmetic:
  - Magnitude = bit15 ? (~v+1) : v, computed in 17 bits so 0x8000 yields 32768.
  - Zero displays "+00000".
- req_ready is 0 during init and during every request. Requests while busy are not lost; the producer holds them.
- Latency: a non-CLEAR request completes 34 byte writes. req_ready reasserts at most 20 + 34*(EN_PULSE_CYC+CMD_WAIT_CYC+2) cycles after acceptance. A CLEAR request issues exactly one byte.
- lcd_rs is 0 for commands and 1 for all 32 characters.

Decomposition:
- Shared package cpu_lcd_pkg holds:
  - opcode constants, shared with the CPU;
  - LCD command bytes (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0);
  - ASCII constants;
  - mnemonic lookup function: opcode to 4 characters.
- Sub-module bcd_converter:
  - sequential double-dabble, 17-bit magnitude to 5 BCD digits;
  - start/done handshake, done within 18 cycles.

Test Plan:
(Bench uses INIT_WAIT_CYC=10, EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8. Monitor samples lcd_data/lcd_rs on each lcd_en falling edge.)
1. Reset release -> commands 0x38, 0x0C, 0x06, 0x01 (rs=0) in order; en width 2, gap 4 (8 after 0x01); req_ready rises only afterwards.
2. ADD, addr 0101, value 0x0007 -> 0x80; "ADD       [0101]"; 0xC0; "          +00007"; req_ready returns.
3. SUB value 0xFFF6 -> line 2 "          -00010". Value 0x8000 -> "-32768". Value 0x7FFF -> "+32767". Value 0 -> "+00000".
4. CLEAR (110) -> exactly one byte, rs=0 0x01, then 8-cycle wait, then req_ready=1; no character bytes.
5. Hold req_valid high, changing fields during busy -> only the first request is displayed; the second is captured on the next req_ready and displayed after.
6. Assert rst during the LINE1 character 5 strobe -> lcd_en=0 in the same cycle; after release, the init sequence repeats from 0x38 and req_ready=0 until it completes.

Source files
------------

// File: rtl/cpu_lcd_pkg.sv
// Shared CPU/LCD definitions: opcodes, HD44780 command bytes, ASCII codes,
// controller state encodings and the opcode-to-mnemonic lookup.
package cpu_lcd_pkg;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'b000,
        OP_ADD     = 3'b001,
        OP_ADDI    = 3'b010,
        OP_SUB     = 3'b011,
        OP_SUBI    = 3'b100,
        OP_MUL     = 3'b101,
        OP_CLEAR   = 3'b110,
        OP_DISPLAY = 3'b111
    } opcode_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_ONE    = 8'h31;
    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MINUS  = 8'h2D;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_CMD,
        ST_IDLE,
        ST_CLEAR,
        ST_CONVERT,
        ST_LINE1,
        ST_LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_START,
        PH_EN,
        PH_WAIT
    } wr_phase_t;

    // Four ASCII characters, leftmost character in bits [31:24].
    function automatic logic [31:0] mnemonic(input opcode_t op);
        logic [31:0] m;
        case (op)
            OP_LOAD:    m = "LOAD";
            OP_ADD:     m = "ADD ";
            OP_ADDI:    m = "ADDI";
            OP_SUB:     m = "SUB ";
            OP_SUBI:    m = "SUBI";
            OP_MUL:     m = "MUL ";
            OP_CLEAR:   m = "CLR ";
            default:    m = "DISP";
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: 17-bit binary to five BCD digits, one shift per
// cycle; done pulses one cycle and the digits hold until the next start.
module bcd_converter
    import cpu_lcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [16:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [36:0] sr;
    logic [36:0] adj;
    logic [4:0]  cnt;
    logic        busy;

    always_comb begin
        adj = sr;
        for (int unsigned i = 0; i < 5; i++) begin
            if (adj[17 + 4*i +: 4] >= 4'd5) begin
                adj[17 + 4*i +: 4] = adj[17 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr   <= {20'd0, bin};
                cnt  <= 5'd17;
                busy <= 1'b1;
            end else if (busy) begin
                sr  <= {adj[35:0], 1'b0};
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[36:17];

endmodule

// File: rtl/lcd_display_controller.sv
// Display-request consumer: formats opcode/address/result as two 16-char lines
// and drives an HD44780 16x2 LCD (8-bit, write-only), including power-up init.
module lcd_display_controller
    import cpu_lcd_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYC = 1000000,
    parameter int unsigned EN_PULSE_CYC  = 25,
    parameter int unsigned CMD_WAIT_CYC  = 2000,
    parameter int unsigned CLR_WAIT_CYC  = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_value,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    lcd_state_t  state;
    wr_phase_t   phase;
    logic [31:0] cnt;
    logic [4:0]  idx;
    opcode_t     op_q;
    logic [3:0]  addr_q;
    logic        neg_q;
    logic [16:0] bcd_bin;
    logic        bcd_start;
    logic        bcd_done;
    logic [19:0] bcd_digits;

    logic [4:0]  sel_idx;
    logic [4:0]  last_idx;
    logic [7:0]  byte_data;
    logic        byte_rs;
    logic [31:0] mnem;
    logic [31:0] wait_len;

    bcd_converter u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .bin   (bcd_bin),
        .done  (bcd_done),
        .bcd   (bcd_digits)
    );

    assign lcd_rw = 1'b0;

    // The byte on the bus is still registered during its wait, so it selects its own wait.
    assign wait_len = (!lcd_rs && lcd_data == LCD_CLEAR) ? CLR_WAIT_CYC : CMD_WAIT_CYC;

    // During the wait the next byte is prepared so it can strobe right as the wait expires.
    always_comb begin
        sel_idx   = (phase == PH_WAIT) ? idx + 5'd1 : idx;
        mnem      = mnemonic(op_q);
        byte_data = '0;
        byte_rs   = 1'b0;
        last_idx  = '0;
        case (state)
            ST_INIT_CMD: begin
                last_idx = 5'd3;
                case (sel_idx)
                    5'd0:    byte_data = LCD_FUNC_SET;
                    5'd1:    byte_data = LCD_DISP_ON;
                    5'd2:    byte_data = LCD_ENTRY;
                    default: byte_data = LCD_CLEAR;
                endcase
            end
            ST_CLEAR: begin
                byte_data = LCD_CLEAR;
            end
            ST_LINE1: begin
                last_idx = 5'd16;
                byte_rs  = (sel_idx != 5'd0);
                case (sel_idx)
                    5'd0:    byte_data = LCD_LINE1;
                    5'd1:    byte_data = mnem[31:24];
                    5'd2:    byte_data = mnem[23:16];
                    5'd3:    byte_data = mnem[15:8];
                    5'd4:    byte_data = mnem[7:0];
                    5'd11:   byte_data = CH_LBRACK;
                    5'd12:   byte_data = addr_q[3] ? CH_ONE : CH_ZERO;
                    5'd13:   byte_data = addr_q[2] ? CH_ONE : CH_ZERO;
                    5'd14:   byte_data = addr_q[1] ? CH_ONE : CH_ZERO;
                    5'd15:   byte_data = addr_q[0] ? CH_ONE : CH_ZERO;
                    5'd16:   byte_data = CH_RBRACK;
                    default: byte_data = CH_SPACE;
                endcase
            end
            ST_LINE2: begin
                last_idx = 5'd16;
                byte_rs  = (sel_idx != 5'd0);
                case (sel_idx)
                    5'd0:    byte_data = LCD_LINE2;
                    5'd11:   byte_data = neg_q ? CH_MINUS : CH_PLUS;
                    5'd12:   byte_data = CH_ZERO | {4'h0, bcd_digits[19:16]};
                    5'd13:   byte_data = CH_ZERO | {4'h0, bcd_digits[15:12]};
                    5'd14:   byte_data = CH_ZERO | {4'h0, bcd_digits[11:8]};
                    5'd15:   byte_data = CH_ZERO | {4'h0, bcd_digits[7:4]};
                    5'd16:   byte_data = CH_ZERO | {4'h0, bcd_digits[3:0]};
                    default: byte_data = CH_SPACE;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            phase     <= PH_START;
            cnt       <= '0;
            idx       <= '0;
            lcd_data  <= '0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            req_ready <= 1'b0;
            op_q      <= OP_LOAD;
            addr_q    <= '0;
            neg_q     <= 1'b0;
            bcd_bin   <= '0;
            bcd_start <= 1'b0;
        end else begin
            bcd_start <= 1'b0;
            case (state)
                ST_INIT_WAIT: begin
                    if (cnt == INIT_WAIT_CYC - 1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        phase <= PH_START;
                        state <= ST_INIT_CMD;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= opcode_t'(req_opcode);
                        addr_q    <= req_addr;
                        neg_q     <= req_value[15];
                        bcd_bin   <= req_value[15] ? ({1'b0, ~req_value} + 17'd1)
                                                   : {1'b0, req_value};
                        idx       <= '0;
                        phase     <= PH_START;
                        if (opcode_t'(req_opcode) == OP_CLEAR) begin
                            state <= ST_CLEAR;
                        end else begin
                            bcd_start <= 1'b1;
                            state     <= ST_CONVERT;
                        end
                    end
                end
                ST_CONVERT: begin
                    if (bcd_done) begin
                        idx   <= '0;
                        phase <= PH_START;
                        state <= ST_LINE1;
                    end
                end
                ST_INIT_CMD, ST_CLEAR, ST_LINE1, ST_LINE2: begin
                    case (phase)
                        PH_START: begin
                            lcd_data <= byte_data;
                            lcd_rs   <= byte_rs;
                            lcd_en   <= 1'b1;
                            cnt      <= '0;
                            phase    <= PH_EN;
                        end
                        PH_EN: begin
                            if (cnt == EN_PULSE_CYC - 1) begin
                                lcd_en <= 1'b0;
                                cnt    <= '0;
                                phase  <= PH_WAIT;
                            end else begin
                                cnt <= cnt + 1;
                            end
                        end
                        PH_WAIT: begin
                            if (cnt == wait_len - 1) begin
                                cnt <= '0;
                                if (idx == last_idx) begin
                                    idx   <= '0;
                                    phase <= PH_START;
                                    if (state == ST_LINE1) begin
                                        state <= ST_LINE2;
                                    end else begin
                                        state     <= ST_IDLE;
                                        req_ready <= 1'b1;
                                    end
                                end else begin
                                    idx      <= idx + 5'd1;
                                    lcd_data <= byte_data;
                                    lcd_rs   <= byte_rs;
                                    lcd_en   <= 1'b1;
                                    phase    <= PH_EN;
                                end
                            end else begin
                                cnt <= cnt + 1;
                            end
                        end
                        default: phase <= PH_START;
                    endcase
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_display_controller.sv
// Scoreboard bench: requests push the expected LCD byte stream built from text
// rules; a monitor pops and compares on every lcd_en falling edge.
module tb_lcd_display_controller;

    localparam int unsigned INIT_W = 10;
    localparam int unsigned EN_W   = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned CLR_W  = 8;
    localparam int PERIOD    = 10;
    localparam int LAT_BOUND = 20 + 34 * (EN_W + CMD_W + 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_opcode = '0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_value = '0;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;

    int total = 0;
    int bad = 0;
    int n_bytes = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_b;
    logic [8:0] exp_b;
    longint rise_t = 0;
    longint fall_t = 0;
    bit have_fall = 0;
    int req_gap = 0;

    lcd_display_controller #(
        .INIT_WAIT_CYC (INIT_W),
        .EN_PULSE_CYC  (EN_W),
        .CMD_WAIT_CYC  (CMD_W),
        .CLR_WAIT_CYC  (CLR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_value  (req_value),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input longint act, input longint lim);
        total++;
        if (act < lim) begin
            bad++;
            $display("FAIL %s: got %0d, want >= %0d", name, act, lim);
        end
    endtask

    task automatic chk_le(input string name, input longint act, input longint lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d, want <= %0d", name, act, lim);
        end
    endtask

    function automatic string mnem_of(input logic [2:0] op);
        case (op)
            3'd0:    return "LOAD";
            3'd1:    return "ADD ";
            3'd2:    return "ADDI";
            3'd3:    return "SUB ";
            3'd4:    return "SUBI";
            3'd5:    return "MUL ";
            default: return "DISP";
        endcase
    endfunction

    function automatic void push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endfunction

    function automatic void push_request(input logic [2:0] op, input logic [3:0] a,
                                         input logic [15:0] v);
        string l1;
        string l2;
        int mag;
        if (op == 3'b110) begin
            exp_q.push_back(9'h001);
            return;
        end
        mag = v[15] ? 65536 - int'(v) : int'(v);
        l1 = {mnem_of(op), "      [", $sformatf("%04b", a), "]"};
        l2 = $sformatf("          %s%05d", v[15] ? "-" : "+", mag);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
    endfunction

    // Monitor: strobe timing and byte content against the scoreboard queue.
    always @(lcd_en) begin
        #1;
        if (rst) begin
            have_fall = 0;
        end else if (lcd_en) begin
            rise_t = $time;
            if (have_fall) chk_ge("en_gap", rise_t - fall_t, req_gap * PERIOD);
        end else begin
            got_b = {lcd_rs, lcd_data};
            chk("en_width", $time - rise_t, EN_W * PERIOD);
            chk("rw_low", lcd_rw, 0);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got rs=%0b data=%02h, want no byte",
                         got_b[8], got_b[7:0]);
            end else begin
                exp_b = exp_q.pop_front();
                if (got_b !== exp_b) begin
                    bad++;
                    $display("FAIL byte%0d: got rs=%0b data=%02h, want rs=%0b data=%02h",
                             n_bytes, got_b[8], got_b[7:0], exp_b[8], exp_b[7:0]);
                end
            end
            n_bytes++;
            fall_t = $time;
            have_fall = 1;
            req_gap = (got_b == 9'h001) ? CLR_W : CMD_W;
        end
    end

    task automatic wait_ready(input int max_cyc, output int cyc, output bit ok);
        cyc = 0;
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if (req_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no req_ready in %0d cycles, want req_ready", max_cyc);
        end
    endtask

    task automatic check_done(input int cyc, input int left);
        chk_le("latency", cyc, LAT_BOUND);
        chk("drained", exp_q.size(), left);
        if (have_fall) chk_ge("ready_gap", ($time - 5) - (fall_t - 1), req_gap * PERIOD);
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [15:0] v);
        int cyc;
        bit ok;
        int nb0;
        wait_ready(LAT_BOUND, cyc, ok);
        req_opcode = op;
        req_addr = a;
        req_value = v;
        req_valid = 1'b1;
        push_request(op, a, v);
        nb0 = n_bytes;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ready_low_after_accept", req_ready, 0);
        wait_ready(LAT_BOUND + 10, cyc, ok);
        if (ok) begin
            check_done(cyc, 0);
            chk("byte_count", n_bytes - nb0, (op == 3'b110) ? 1 : 34);
        end
    endtask

    task automatic reset_and_init();
        int cyc;
        bit ok;
        repeat (3) @(negedge clk);
        push_init();
        rst = 1'b0;
        wait_ready(LAT_BOUND, cyc, ok);
        if (ok) check_done(cyc, 0);
    endtask

    initial begin
        int cyc;
        bit ok;
        int base;
        bit found;
        logic [15:0] v;

        #1;
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_ready", req_ready, 0);
        reset_and_init();

        send(3'b001, 4'b0101, 16'h0007);
        send(3'b011, 4'b0000, 16'hFFF6);
        send(3'b000, 4'b1111, 16'h8000);
        send(3'b010, 4'b1000, 16'h7FFF);
        send(3'b111, 4'b0110, 16'h0000);
        send(3'b110, 4'b0011, 16'h1234);

        // Held request with fields changed while busy: both displayed in order.
        wait_ready(LAT_BOUND, cyc, ok);
        req_opcode = 3'b011; req_addr = 4'b1010; req_value = 16'h0003; req_valid = 1'b1;
        push_request(3'b011, 4'b1010, 16'h0003);
        @(posedge clk);
        #1;
        req_opcode = 3'b101; req_addr = 4'b0011; req_value = 16'hFF00;
        push_request(3'b101, 4'b0011, 16'hFF00);
        wait_ready(LAT_BOUND + 10, cyc, ok);
        if (ok) check_done(cyc, 34);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("second_captured", req_ready, 0);
        wait_ready(LAT_BOUND + 10, cyc, ok);
        if (ok) check_done(cyc, 0);

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 4))
                0: v = 16'h0000;
                1: v = 16'h8000;
                2: v = 16'h7FFF;
                3: v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), v);
        end

        // Reset while the fifth LINE1 character is strobing.
        wait_ready(LAT_BOUND, cyc, ok);
        req_opcode = 3'b100; req_addr = 4'b1100; req_value = 16'h0042; req_valid = 1'b1;
        push_request(3'b100, 4'b1100, 16'h0042);
        base = n_bytes;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < LAT_BOUND; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1 && n_bytes == base + 5) begin
                found = 1;
                break;
            end
        end
        chk("char5_strobe_seen", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_en", lcd_en, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_data", lcd_data, 0);
        exp_q.delete();
        reset_and_init();
        send(3'b101, 4'b0001, 16'hFFFE);

        repeat (5) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        total++;
        bad++;
        $display("FAIL watchdog: got no completion, want completion before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
